axis_frame_len_mon: RTL
=======================

Name: axis_frame_len_mon

Overview:
Passive AXI-Stream frame-length monitor. It is the parametrised successor to the single-channel frame-length counter. It counts bytes per frame from any tkeep pattern (popcount) and saturates instead of wrapping. It flags runt, giant and saturated frames against runtime limits, and delivers each result through a valid/ready holding register with drop accounting. It also keeps running statistics: frame count, minimum length and maximum length. It taps an existing stream (tvalid/tready/tkeep/tlast only) and sits beside MAC/DMA datapaths, feeding CSR or stats logic.

Parameters:
DATA_WIDTH, 64, monitored stream data width in bits (must be a multiple of 8 when KEEP_ENABLE=1)
KEEP_ENABLE, (DATA_WIDTH>8), 1 = use tkeep byte count; 0 = each beat counts 1
KEEP_WIDTH, DATA_WIDTH/8, tkeep width
LEN_WIDTH, 16, frame length / limit width in bytes
COUNT_WIDTH, 32, statistics counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
monitor_axis_tkeep  in  KEEP_WIDTH  tapped tkeep
monitor_axis_tvalid  in  1  tapped tvalid
monitor_axis_tready  in  1  tapped tready
monitor_axis_tlast  in  1  tapped tlast
cfg_min_len  in  LEN_WIDTH  runt threshold (len < min is runt)
cfg_max_len  in  LEN_WIDTH  giant threshold (len > max is giant)
stat_clear  in  1  synchronous statistics clear pulse
frame_len  out  LEN_WIDTH  completed frame length
frame_len_sat  out  1  accumulator saturated during this frame
frame_len_runt  out  1  frame shorter than cfg_min_len
frame_len_giant  out  1  frame longer than cfg_max_len
frame_len_valid  out  1  result held valid
frame_len_ready  in  1  consumer accepts result
frame_active  out  1  mid-frame (at least one non-last beat seen)
frame_dropped  out  1  one-cycle pulse: result lost, holding register full
stat_frames  out  COUNT_WIDTH  completed frames, saturating
stat_drops  out  COUNT_WIDTH  dropped results, saturating
stat_min_len  out  LEN_WIDTH  smallest completed length
stat_max_len  out  LEN_WIDTH  largest completed length

Behaviour:
- Beat = tvalid & tready. Beat bytes = popcount(tkeep) if KEEP_ENABLE, else 1. Any tkeep pattern is legal; tkeep=0 adds 0.
- Accumulator acc (LEN_WIDTH) resets to 0. On a non-last beat: acc = sat_add(acc, bytes); sat_flag |= overflow; frame_active=1.
- On a tlast beat: L = sat_add(acc, bytes); S = sat_flag | overflow. Then acc=0, sat_flag=0, frame_active=0 next cycle.
- sat_add clamps to 2^LEN_WIDTH-1.
- Result path: L, S, runt=(L<cfg_min_len), giant=(L>cfg_max_len) are registered. cfg is sampled on the tlast cycle.
- frame_len_valid rises the cycle after the tlast beat (latency 1). Outputs stay stable while valid & !ready. The holding register clears on valid & ready.
- Holding-register full (valid & !ready) on a tlast beat: the new result is discarded. frame_dropped pulses the next cycle and stat_drops increments. The held result is unchanged.
- If valid & ready coincides with a tlast beat, the new result is loaded (no drop, no bubble).
- Statistics update on every completed frame, dropped or not, the cycle after tlast: stat_frames+1; stat_min_len=min; stat_max_len=max. Counters saturate at all-ones.
- stat_clear: stat_frames=0, stat_drops=0, stat_min_len=all-ones, stat_max_len=0. If a frame completes the same cycle, stats are cleared then updated with that frame only (frames=1, min=max=L). Clear does not affect acc or the holding register.
- Back-to-back single-beat frames (tlast every cycle) are fully supported: each beat is its own frame.
- Reset (async assert, sync release): acc=0, sat_flag=0, frame_active=0, frame_len=0, flags=0, frame_len_valid=0, frame_dropped=0, stat_frames=0, stat_drops=0, stat_min_len=all-ones, stat_max_len=0. A partial frame in flight at reset is discarded; the first beat after release starts a new frame.

Decomposition:
- Shared package axis_mon_pkg: sat_add and max-value helpers, and the LEN/COUNT all-ones constant function.
- Sub-module axis_keep_popcount (parameter KEEP_WIDTH; combinational popcount of tkeep, output width $clog2(KEEP_WIDTH+1)).
- Everything else is in axis_frame_len_mon.

Test Plan:
- 64-bit, 3 beats tkeep=FF,FF,0F(tlast), ready=1 -> frame_len=20 one cycle after tlast; stat_frames=1, min=max=20.
- Sparse tkeep: 1 beat tkeep=0xA5 with tlast -> frame_len=4; tkeep=0x00 with tlast -> frame_len=0, runt=1 when cfg_min_len=1.
- LEN_WIDTH=8, 40 beats of FF + tlast -> frame_len=255, frame_len_sat=1, giant=1 with cfg_max_len=200.
- frame_len_ready=0, two 1-beat frames (len 8, then 3) -> frame_len holds 8; frame_dropped pulses once; stat_drops=1, stat_frames=2, min=3, max=8.
- stat_clear on the same cycle as a tlast completing len 16 -> stat_frames=1, min=max=16, stat_drops=0.
- rst_n pulsed low mid-frame after 2 beats of FF, then a 1-beat frame tkeep=03 -> frame_len=2, no stale bytes, all stats at reset values before that frame.

Source files
------------

// File: rtl/axis_mon_pkg.sv
// Shared helpers for the AXI-Stream monitors: saturating arithmetic and all-ones constants.
package axis_mon_pkg;

    localparam int unsigned MON_MAX_W = 64;

    typedef logic [MON_MAX_W-1:0] mon_word_t;

    typedef struct packed {
        logic sat;
        logic runt;
        logic giant;
    } len_flags_t;

    function automatic mon_word_t all_ones(input int unsigned w);
        if (w >= MON_MAX_W) return '1;
        return (mon_word_t'(1) << w) - mon_word_t'(1);
    endfunction

    function automatic logic add_ovf(input mon_word_t a, input mon_word_t b, input int unsigned w);
        logic [MON_MAX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s > {1'b0, all_ones(w)};
    endfunction

    // Sum clamped to the largest value representable in w bits
    function automatic mon_word_t sat_add(input mon_word_t a, input mon_word_t b, input int unsigned w);
        logic [MON_MAX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, all_ones(w)}) return all_ones(w);
        return s[MON_MAX_W-1:0];
    endfunction

    function automatic mon_word_t max_val(input mon_word_t a, input mon_word_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic mon_word_t min_val(input mon_word_t a, input mon_word_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/axis_keep_popcount.sv
// Combinational count of set tkeep bits.
module axis_keep_popcount #(
    parameter int unsigned KEEP_WIDTH = 8,
    localparam int unsigned CNT_WIDTH = $clog2(KEEP_WIDTH + 1)
) (
    input  logic [KEEP_WIDTH-1:0] keep,
    output logic [CNT_WIDTH-1:0]  count_c
);

    always_comb begin
        count_c = '0;
        for (int i = 0; i < int'(KEEP_WIDTH); i++) begin
            count_c = count_c + CNT_WIDTH'(keep[i]);
        end
    end

endmodule

// File: rtl/axis_frame_len_mon.sv
// Passive AXI-Stream frame-length monitor: saturating byte count per frame, runt/giant
// flags, held result with drop accounting, and running frame statistics.
module axis_frame_len_mon
    import axis_mon_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int unsigned KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
    parameter int unsigned LEN_WIDTH   = 16,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [KEEP_WIDTH-1:0]  monitor_axis_tkeep,
    input  logic                   monitor_axis_tvalid,
    input  logic                   monitor_axis_tready,
    input  logic                   monitor_axis_tlast,
    input  logic [LEN_WIDTH-1:0]   cfg_min_len,
    input  logic [LEN_WIDTH-1:0]   cfg_max_len,
    input  logic                   stat_clear,
    output logic [LEN_WIDTH-1:0]   frame_len,
    output logic                   frame_len_sat,
    output logic                   frame_len_runt,
    output logic                   frame_len_giant,
    output logic                   frame_len_valid,
    input  logic                   frame_len_ready,
    output logic                   frame_active,
    output logic                   frame_dropped,
    output logic [COUNT_WIDTH-1:0] stat_frames,
    output logic [COUNT_WIDTH-1:0] stat_drops,
    output logic [LEN_WIDTH-1:0]   stat_min_len,
    output logic [LEN_WIDTH-1:0]   stat_max_len
);

    localparam int unsigned PC_WIDTH = $clog2(KEEP_WIDTH + 1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONES = LEN_WIDTH'(all_ones(LEN_WIDTH));

    logic [LEN_WIDTH-1:0]   acc;
    logic                   sat_flag;
    logic [LEN_WIDTH-1:0]   beat_bytes;
    logic                   beat;
    logic                   done;
    logic                   hold_busy;
    logic                   drop_c;
    logic [LEN_WIDTH-1:0]   len_c;
    logic                   ovf_c;
    len_flags_t             flags_c;

    logic [COUNT_WIDTH-1:0] frames_base, frames_next;
    logic [COUNT_WIDTH-1:0] drops_base, drops_next;
    logic [LEN_WIDTH-1:0]   min_base, min_next;
    logic [LEN_WIDTH-1:0]   max_base, max_next;

    generate
        if (KEEP_ENABLE) begin : g_keep
            logic [PC_WIDTH-1:0] keep_count;
            axis_keep_popcount #(.KEEP_WIDTH(KEEP_WIDTH)) u_popcount (
                .keep    (monitor_axis_tkeep),
                .count_c (keep_count)
            );
            assign beat_bytes = LEN_WIDTH'(keep_count);
        end else begin : g_no_keep
            assign beat_bytes = LEN_WIDTH'(1);
        end
    endgenerate

    assign beat      = monitor_axis_tvalid & monitor_axis_tready;
    assign done      = beat & monitor_axis_tlast;
    assign hold_busy = frame_len_valid & ~frame_len_ready;
    assign drop_c    = done & hold_busy;

    // Length including the current beat; becomes the new acc or the frame result
    always_comb begin
        len_c         = LEN_WIDTH'(sat_add(mon_word_t'(acc), mon_word_t'(beat_bytes), LEN_WIDTH));
        ovf_c         = add_ovf(mon_word_t'(acc), mon_word_t'(beat_bytes), LEN_WIDTH);
        flags_c.sat   = sat_flag | ovf_c;
        flags_c.runt  = len_c < cfg_min_len;
        flags_c.giant = len_c > cfg_max_len;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            sat_flag     <= 1'b0;
            frame_active <= 1'b0;
        end else if (beat) begin
            if (monitor_axis_tlast) begin
                acc          <= '0;
                sat_flag     <= 1'b0;
                frame_active <= 1'b0;
            end else begin
                acc          <= len_c;
                sat_flag     <= flags_c.sat;
                frame_active <= 1'b1;
            end
        end
    end

    // Holding register: a result arriving while the previous one is unaccepted is lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_len       <= '0;
            frame_len_sat   <= 1'b0;
            frame_len_runt  <= 1'b0;
            frame_len_giant <= 1'b0;
            frame_len_valid <= 1'b0;
            frame_dropped   <= 1'b0;
        end else begin
            frame_dropped <= drop_c;
            if (done && !hold_busy) begin
                frame_len       <= len_c;
                frame_len_sat   <= flags_c.sat;
                frame_len_runt  <= flags_c.runt;
                frame_len_giant <= flags_c.giant;
                frame_len_valid <= 1'b1;
            end else if (frame_len_valid && frame_len_ready) begin
                frame_len_valid <= 1'b0;
            end
        end
    end

    // Clear applies first so a frame completing alongside it is still counted
    always_comb begin
        frames_base = stat_clear ? '0 : stat_frames;
        drops_base  = stat_clear ? '0 : stat_drops;
        min_base    = stat_clear ? LEN_ONES : stat_min_len;
        max_base    = stat_clear ? '0 : stat_max_len;
        frames_next = frames_base;
        drops_next  = drops_base;
        min_next    = min_base;
        max_next    = max_base;
        if (done) begin
            frames_next = COUNT_WIDTH'(sat_add(mon_word_t'(frames_base), mon_word_t'(1), COUNT_WIDTH));
            min_next    = LEN_WIDTH'(min_val(mon_word_t'(min_base), mon_word_t'(len_c)));
            max_next    = LEN_WIDTH'(max_val(mon_word_t'(max_base), mon_word_t'(len_c)));
        end
        if (drop_c) begin
            drops_next = COUNT_WIDTH'(sat_add(mon_word_t'(drops_base), mon_word_t'(1), COUNT_WIDTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frames  <= '0;
            stat_drops   <= '0;
            stat_min_len <= LEN_ONES;
            stat_max_len <= '0;
        end else begin
            stat_frames  <= frames_next;
            stat_drops   <= drops_next;
            stat_min_len <= min_next;
            stat_max_len <= max_next;
        end
    end

endmodule
